// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start-bit qualification, 3-sample majority
// voting, deserializer sequencing, and parity/stop checking with one result per frame.
module uart_rx_ctrl #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sampling_clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  sampled_bit,
  output logic                  bit_strobe,
  output logic                  deser_en,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] SAMPLE0_TICK = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] SAMPLE1_TICK = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] VOTE_TICK    = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] CHECK_TICK   = EW'(PRESCALE / 2 + 2);
  localparam logic [EW-1:0] LAST_TICK    = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] LAST_BIT     = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [EW-1:0] edge_cnt_reg, edge_cnt_next;
  logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
  logic          sample0_reg, sample1_reg;
  logic          par_en_reg, par_typ_reg;
  logic          par_fail_reg, stp_fail_reg;

  logic          last_tick, vote_tick, check_tick;
  logic          majority, enter_start, strobe_next, frame_done, expected_parity;

  always_comb begin
    last_tick       = (edge_cnt_reg == LAST_TICK);
    vote_tick       = (edge_cnt_reg == VOTE_TICK);
    check_tick      = (edge_cnt_reg == CHECK_TICK);
    majority        = (sample0_reg & sample1_reg) | (sample0_reg & rx_in) | (sample1_reg & rx_in);
    expected_parity = (^p_data) ^ par_typ_reg;
    frame_done      = (state_reg == STOP) && last_tick;

    state_next    = state_reg;
    edge_cnt_next = last_tick ? '0 : edge_cnt_reg + 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    enter_start   = 1'b0;

    case (state_reg)
      IDLE: begin
        edge_cnt_next = '0;
        if (!rx_in) begin
          state_next    = START;
          edge_cnt_next = EW'(1);
          enter_start   = 1'b1;
        end
      end
      START: begin
        // A start bit that votes high was line noise: abandon it mid-bit.
        if (vote_tick && majority) begin
          state_next    = IDLE;
          edge_cnt_next = '0;
        end else if (last_tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (last_tick) begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT)
            state_next = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (last_tick)
          state_next = STOP;
      end
      STOP: begin
        if (last_tick) begin
          // Line already low at the end of stop: next frame's start bit, no idle tick needed.
          if (!rx_in) begin
            state_next    = START;
            edge_cnt_next = EW'(1);
            enter_start   = 1'b1;
          end else begin
            state_next    = IDLE;
            edge_cnt_next = '0;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        edge_cnt_next = '0;
      end
    endcase

    strobe_next = vote_tick && (state_reg != IDLE) && !((state_reg == START) && majority);
  end

  always_ff @(posedge sampling_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sample0_reg  <= 1'b1;
      sample1_reg  <= 1'b1;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
      par_fail_reg <= 1'b0;
      stp_fail_reg <= 1'b0;
      sampled_bit  <= 1'b1;
      bit_strobe   <= 1'b0;
      deser_en     <= 1'b0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      edge_cnt_reg <= edge_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;

      if (state_reg != IDLE) begin
        if (edge_cnt_reg == SAMPLE0_TICK) sample0_reg <= rx_in;
        if (edge_cnt_reg == SAMPLE1_TICK) sample1_reg <= rx_in;
        if (vote_tick)                    sampled_bit <= majority;
      end

      if (enter_start) begin
        par_en_reg   <= par_en;
        par_typ_reg  <= par_typ;
        par_fail_reg <= 1'b0;
        stp_fail_reg <= 1'b0;
      end else begin
        if ((state_reg == PARITY) && check_tick && (sampled_bit != expected_parity))
          par_fail_reg <= 1'b1;
        if ((state_reg == STOP) && check_tick && !sampled_bit)
          stp_fail_reg <= 1'b1;
      end

      bit_strobe <= strobe_next;
      deser_en   <= (state_next == DATA);
      busy       <= (state_next != IDLE);
      data_valid <= frame_done && !par_fail_reg && !stp_fail_reg;
      par_err    <= frame_done && par_fail_reg;
      stp_err    <= frame_done && stp_fail_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a scoreboard of expected frame results
// (kind, data, arrival cycle) drained as the controller reports each frame.
module tb_uart_rx_ctrl;

  localparam int P  = 8;
  localparam int DW = 8;

  logic          sampling_clk = 1'b0;
  logic          rst_n        = 1'b0;
  logic          rx_in        = 1'b1;
  logic          par_en       = 1'b0;
  logic          par_typ      = 1'b0;
  logic [DW-1:0] p_data       = '0;
  logic          sampled_bit, bit_strobe, deser_en;
  logic          data_valid, par_err, stp_err, busy;

  uart_rx_ctrl #(.PRESCALE(P), .DATA_WIDTH(DW)) dut (
    .sampling_clk(sampling_clk),
    .rst_n       (rst_n),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .p_data      (p_data),
    .sampled_bit (sampled_bit),
    .bit_strobe  (bit_strobe),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .busy        (busy)
  );

  always #5 sampling_clk = ~sampling_clk;

  int cyc = 0;
  always @(posedge sampling_clk) cyc <= cyc + 1;

  // Stand-in deserializer: shifts LSB-first on the qualified strobe.
  always @(posedge sampling_clk)
    if (deser_en && bit_strobe) p_data <= {sampled_bit, p_data[DW-1:1]};

  typedef struct {
    logic [2:0] kind;   // {stp_err, par_err, data_valid}
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  logic bits_q[$];
  int   valid_cyc_q[$];
  int   strobe_cnt = 0;
  int   n_checks   = 0;
  int   n_fail     = 0;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  always @(negedge sampling_clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (bit_strobe) strobe_cnt++;
      if (bit_strobe && deser_en) bits_q.push_back(sampled_bit);
      if (data_valid || par_err || stp_err) begin
        $display("frame result kind=%b p_data=%02h cyc=%0d", {stp_err, par_err, data_valid}, p_data, cyc);
        if (data_valid) valid_cyc_q.push_back(cyc);
        if (sb_q.size() == 0) begin
          check_value("unexpected_result", 32'({stp_err, par_err, data_valid}), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_value("result_kind", 32'({stp_err, par_err, data_valid}), 32'(e.kind));
          check_value("result_cycle", 32'(cyc), 32'(e.cyc));
          if (e.kind[0]) check_value("p_data", 32'(p_data), 32'(e.data));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (P) @(negedge sampling_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit, input logic stop_bit);
    exp_t e;
    logic par_ok;
    par_en = with_par;
    par_ok = !with_par || (((^d) ^ par_typ) == par_bit);
    e.kind = {!stop_bit, !par_ok, stop_bit && par_ok};
    e.data = d;
    e.cyc  = cyc + (10 + int'(with_par)) * P;
    sb_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (with_par) send_bit(par_bit);
    send_bit(stop_bit);
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge sampling_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5;
    int s0;
    a5 = 8'hA5;

    // Reset state
    repeat (3) @(negedge sampling_clk);
    check_value("rst_sampled_bit", 32'(sampled_bit), 32'd1);
    check_value("rst_outputs", 32'({bit_strobe, deser_en, data_valid, par_err, stp_err, busy}), 32'd0);
    rst_n = 1'b1;
    idle(4);

    // 1: 8N1 0xA5
    bits_q.delete();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(4);
    check_value("t1_bit_count", 32'(bits_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < bits_q.size()) check_value($sformatf("t1_bit%0d", i), 32'(bits_q[i]), 32'(a5[i]));
    check_value("t1_pending", 32'(sb_q.size()), 32'd0);

    // 2: even parity, good then bad parity bit
    par_typ = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(4);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle(4);
    par_typ = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle(4);
    par_typ = 1'b0;
    check_value("t2_pending", 32'(sb_q.size()), 32'd0);

    // 3: stop bit low -> stp_err and straight into START
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_value("t3_busy_restart", 32'(busy), 32'd1);
    idle(12);
    check_value("t3_busy_after_glitch", 32'(busy), 32'd0);
    check_value("t3_pending", 32'(sb_q.size()), 32'd0);

    // 4: two-tick glitch, then a good frame
    s0 = strobe_cnt;
    rx_in = 1'b0;
    repeat (2) @(negedge sampling_clk);
    rx_in = 1'b1;
    repeat (4) @(negedge sampling_clk);
    check_value("t4_busy_tick6", 32'(busy), 32'd0);
    idle(6);
    check_value("t4_no_strobe", 32'(strobe_cnt), 32'(s0));
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle(4);

    // 5: back-to-back frames
    valid_cyc_q.delete();
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1);
    idle(4);
    check_value("t5_valid_count", 32'(valid_cyc_q.size()), 32'd2);
    if (valid_cyc_q.size() == 2)
      check_value("t5_spacing", 32'(valid_cyc_q[1] - valid_cyc_q[0]), 32'd80);

    // 6: reset mid-frame (bit 4), then a fresh frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    repeat (3) @(negedge sampling_clk);
    rst_n = 1'b0;
    #1;
    check_value("t6_rst_sampled_bit", 32'(sampled_bit), 32'd1);
    check_value("t6_rst_outputs", 32'({bit_strobe, deser_en, data_valid, par_err, stp_err, busy}), 32'd0);
    rx_in = 1'b1;
    repeat (3) @(negedge sampling_clk);
    rst_n = 1'b1;
    idle(3);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
    idle(6);
    check_value("final_pending", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side frame controller for the UART RX path. It oversamples rx_in on sampling_clk, detects and qualifies the start bit, and majority-votes each bit. It sequences the deserializer through deser_en and a per-bit strobe, checks parity and stop bits, and reports one result per frame: data_valid, par_err or stp_err.

Parameters:
PRESCALE, 8, sampling_clk ticks per bit; even, >= 8, <= 32
DATA_WIDTH, 8, data bits per frame, sent LSB first

Ports:
sampling_clk  in  1  oversampling clock
rst_n  in  1  reset
rx_in  in  1  serial line, idle high, already synchronised
par_en  in  1  1 = frame carries a parity bit
par_typ  in  1  0 = even parity, 1 = odd parity
p_data  in  DATA_WIDTH  parallel word from the deserializer
sampled_bit  out  1  majority-voted value of the current bit
bit_strobe  out  1  one-cycle pulse; sampled_bit is valid this cycle
deser_en  out  1  high while in DATA; the deserializer shifts on deser_en && bit_strobe
data_valid  out  1  one-cycle pulse; p_data holds a good frame
par_err  out  1  one-cycle pulse on parity mismatch
stp_err  out  1  one-cycle pulse when the stop bit is sampled 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is sampling_clk. All outputs are registered.
- Reset values: sampled_bit=1; all other outputs 0; state=IDLE; edge_cnt=0; bit_cnt=0.
- States are IDLE, START, DATA, PARITY, STOP.
- edge_cnt counts 0..PRESCALE-1 within each bit. Tick PRESCALE-1 is the last tick of the bit; edge_cnt then wraps to 0 and the FSM advances.
- IDLE: on an edge where rx_in==0, go to START with edge_cnt=1. That edge is tick 0 of the start bit.
- Sampling: rx_in is captured at ticks P/2-1, P/2 and P/2+1. At the edge ending tick P/2+1, sampled_bit is loaded with the 2-of-3 majority. bit_strobe is high during tick P/2+2 (tick 6 for P=8) in START, DATA, PARITY and STOP.
- START: if the majority is 1, the start bit is a glitch. Return to IDLE at tick P/2+2 with no strobe and no flags. Otherwise, at the last tick go to DATA with bit_cnt=0.
- DATA: deser_en is high for the whole state. bit_cnt increments at each bit end. After bit DATA_WIDTH-1, go to PARITY if par_en is set, otherwise go to STOP.
- par_en and par_typ are latched on the IDLE->START transition. Changes mid-frame are ignored.
- PARITY: expected = ^p_data XOR par_typ. Compare expected with sampled_bit at tick P/2+2. On mismatch, set an internal par_fail flag. At the last tick go to STOP.
- STOP: at tick P/2+2, a sampled 0 sets stp_fail. At the last tick:
  - pulse stp_err if stp_fail is set;
  - pulse par_err if par_fail is set;
  - pulse data_valid only if neither flag is set.
  - All three are registered and appear in the cycle after the last tick.
- At the STOP last tick, if rx_in==0 go directly to START with edge_cnt=1, so back-to-back frames need no idle tick. Otherwise go to IDLE.
- Frame length from falling-edge detection to data_valid high:
  - (1+DATA_WIDTH+par_en+1)*PRESCALE cycles;
  - 80 cycles for 8N1 at P=8;
  - 88 cycles with parity.
- Internal failure flags clear on entry to START.
- Reset asserted mid-frame returns to reset values immediately. No result flags are pulsed for the aborted frame.
- Exactly one of data_valid, par_err or stp_err fires per completed frame, except that par_err and stp_err may pulse together.

Test Plan:
1. P=8, 8N1, send 0xA5 LSB first with idle high before and after -> 8 bit_strobe pulses with deser_en high, sampled_bit sequence 1,0,1,0,0,1,0,1, p_data=0xA5, data_valid high exactly 80 cycles after the start edge, no error flags.
2. par_en=1, par_typ=0, send 0x07 with parity bit 1 -> data_valid at cycle 88; repeat with parity bit 0 -> par_err pulses once, no data_valid.
3. 8N1 frame 0x3C with the stop bit driven 0 -> stp_err pulses once, no data_valid, FSM re-enters START because rx_in==0.
4. rx_in low for 2 ticks then high (glitch) -> no bit_strobe, busy drops by tick 6, FSM in IDLE; a following valid 0x55 frame is received correctly.
5. Two back-to-back 8N1 frames 0x12 and 0x34 with no idle gap -> two data_valid pulses exactly 80 cycles apart, correct data each.
6. Deassert rst_n at bit 4 of a frame -> all outputs at reset values immediately; after release, a fresh 0xF0 frame gives data_valid and correct p_data.
